ps2_keyboard_matrix: RTL and testbench

PS2_KEYBOARD_MATRIX -- requirements
Module: ps2_keyboard_matrix

---
 rtl/ps2_keyboard_matrix.sv | 242 ++++++++++++++++++++++++
 tb/tb_ps2_keyboard_matrix.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_matrix.sv
// PS/2 Set-2 keyboard receiver that maintains a ZX Spectrum style 8x5 key matrix.
// The CPU reads the matrix through the active-low half-row select A_hi.
module ps2_keyboard_matrix (
   input  logic       clk_cpu,
   input  logic       reset,
   input  logic       PS2_CLK,
   input  logic       PS2_DAT,
   input  logic [7:0] A_hi,
   output logic [4:0] key_row,
   output logic       pressed,
   output logic       frame_err
);

   typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

   localparam logic [13:0] TmoLast = 14'd11999;  // counter value one cycle before 12000

   // synchroniser / filter
   logic [1:0] r_clk_s, r_dat_s;
   logic [3:0] r_clk_hist;
   logic       r_clk_f;
   logic       w_fall, w_dat;

   // receiver
   state_e      r_state, w_state_d;
   logic [2:0]  r_bit_cnt, w_bit_cnt_d;
   logic [7:0]  r_shift, w_shift_d;
   logic        r_par, w_par_d;
   logic [13:0] r_tmo, w_tmo_d;
   logic        r_frame_err, w_frame_err_d;
   logic        r_byte_vld, w_byte_vld_d;
   logic [7:0]  r_byte, w_byte_d;

   // decoder
   logic        r_ext, r_brk;
   logic [39:0] r_mat;
   logic [4:0]  r_virt;
   logic        r_pressed;
   logic        w_map_hit, w_virt_hit;
   logic [5:0]  w_map_idx;
   logic [2:0]  w_virt_idx;
   logic [39:0] w_virt_exp, w_eff;

   // Synchronise the raw PS/2 lines and debounce the clock over 4 samples
   always_ff @(posedge clk_cpu) begin
      if (reset) begin
         r_clk_s    <= 2'b11;
         r_dat_s    <= 2'b11;
         r_clk_hist <= 4'hF;
         r_clk_f    <= 1'b1;
      end else begin
         r_clk_s    <= {r_clk_s[0], PS2_CLK};
         r_dat_s    <= {r_dat_s[0], PS2_DAT};
         r_clk_hist <= {r_clk_hist[2:0], r_clk_s[1]};
         if (r_clk_hist == 4'h0) begin
            r_clk_f <= 1'b0;
         end else if (r_clk_hist == 4'hF) begin
            r_clk_f <= 1'b1;
         end
      end
   end

   // The falling edge is the cycle on which the filtered clock is about to drop
   assign w_fall = r_clk_f & (r_clk_hist == 4'h0);
   assign w_dat  = r_dat_s[1];

   // Receive FSM state register and datapath
   always_ff @(posedge clk_cpu) begin
      if (reset) begin
         r_state     <= StIdle;
         r_bit_cnt   <= 3'd0;
         r_shift     <= 8'h00;
         r_par       <= 1'b0;
         r_tmo       <= 14'd0;
         r_frame_err <= 1'b0;
         r_byte_vld  <= 1'b0;
         r_byte      <= 8'h00;
      end else begin
         r_state     <= w_state_d;
         r_bit_cnt   <= w_bit_cnt_d;
         r_shift     <= w_shift_d;
         r_par       <= w_par_d;
         r_tmo       <= w_tmo_d;
         r_frame_err <= w_frame_err_d;
         r_byte_vld  <= w_byte_vld_d;
         r_byte      <= w_byte_d;
      end
   end

   // Receive FSM next state: one step per filtered falling edge, plus frame timeout
   always_comb begin
      w_state_d     = r_state;
      w_bit_cnt_d   = r_bit_cnt;
      w_shift_d     = r_shift;
      w_par_d       = r_par;
      w_frame_err_d = 1'b0;
      w_byte_vld_d  = 1'b0;
      w_byte_d      = r_byte;
      w_tmo_d       = (w_fall || r_state == StIdle) ? 14'd0 : r_tmo + 14'd1;
      if (w_fall) begin
         case (r_state)
            StIdle: begin
               if (!w_dat) begin
                  w_state_d   = StData;
                  w_bit_cnt_d = 3'd0;
               end else begin
                  w_frame_err_d = 1'b1;
               end
            end
            StData: begin
               w_shift_d = {w_dat, r_shift[7:1]};
               if (r_bit_cnt == 3'd7) begin
                  w_state_d = StParity;
               end else begin
                  w_bit_cnt_d = r_bit_cnt + 3'd1;
               end
            end
            StParity: begin
               w_par_d   = w_dat;
               w_state_d = StStop;
            end
            StStop: begin
               w_state_d = StIdle;
               if (w_dat && ((^r_shift) ^ r_par)) begin
                  w_byte_vld_d = 1'b1;
                  w_byte_d     = r_shift;
               end else begin
                  w_frame_err_d = 1'b1;
               end
            end
            default: w_state_d = StIdle;
         endcase
      end else if (r_state != StIdle && r_tmo == TmoLast) begin
         w_state_d     = StIdle;
         w_frame_err_d = 1'b1;
         w_tmo_d       = 14'd0;
      end
   end

   // Translate the current code (with ext flag) into a matrix or virtual-key index
   always_comb begin
      w_map_hit  = 1'b1;
      w_map_idx  = 6'd0;
      w_virt_hit = 1'b0;
      w_virt_idx = 3'd0;
      if (r_ext) begin
         w_map_hit = 1'b0;
         case (r_byte)
            8'h14: begin w_map_hit  = 1'b1; w_map_idx  = 6'd36; end
            8'h6B: begin w_virt_hit = 1'b1; w_virt_idx = 3'd1;  end
            8'h72: begin w_virt_hit = 1'b1; w_virt_idx = 3'd2;  end
            8'h75: begin w_virt_hit = 1'b1; w_virt_idx = 3'd3;  end
            8'h74: begin w_virt_hit = 1'b1; w_virt_idx = 3'd4;  end
            default: ;
         endcase
      end else begin
         case (r_byte)
            8'h12, 8'h59: w_map_idx = 6'd0;
            8'h1A: w_map_idx = 6'd1;   8'h22: w_map_idx = 6'd2;
            8'h21: w_map_idx = 6'd3;   8'h2A: w_map_idx = 6'd4;
            8'h1C: w_map_idx = 6'd5;   8'h1B: w_map_idx = 6'd6;
            8'h23: w_map_idx = 6'd7;   8'h2B: w_map_idx = 6'd8;
            8'h34: w_map_idx = 6'd9;   8'h15: w_map_idx = 6'd10;
            8'h1D: w_map_idx = 6'd11;  8'h24: w_map_idx = 6'd12;
            8'h2D: w_map_idx = 6'd13;  8'h2C: w_map_idx = 6'd14;
            8'h16: w_map_idx = 6'd15;  8'h1E: w_map_idx = 6'd16;
            8'h26: w_map_idx = 6'd17;  8'h25: w_map_idx = 6'd18;
            8'h2E: w_map_idx = 6'd19;  8'h45: w_map_idx = 6'd20;
            8'h46: w_map_idx = 6'd21;  8'h3E: w_map_idx = 6'd22;
            8'h3D: w_map_idx = 6'd23;  8'h36: w_map_idx = 6'd24;
            8'h4D: w_map_idx = 6'd25;  8'h44: w_map_idx = 6'd26;
            8'h43: w_map_idx = 6'd27;  8'h3C: w_map_idx = 6'd28;
            8'h35: w_map_idx = 6'd29;  8'h5A: w_map_idx = 6'd30;
            8'h4B: w_map_idx = 6'd31;  8'h42: w_map_idx = 6'd32;
            8'h3B: w_map_idx = 6'd33;  8'h33: w_map_idx = 6'd34;
            8'h29: w_map_idx = 6'd35;  8'h14: w_map_idx = 6'd36;
            8'h3A: w_map_idx = 6'd37;  8'h31: w_map_idx = 6'd38;
            8'h32: w_map_idx = 6'd39;
            8'h66: begin w_map_hit = 1'b0; w_virt_hit = 1'b1; w_virt_idx = 3'd0; end
            default: w_map_hit = 1'b0;
         endcase
      end
   end

   // Apply prefixes and make/break codes to the direct and virtual key state
   always_ff @(posedge clk_cpu) begin
      if (reset) begin
         r_ext     <= 1'b0;
         r_brk     <= 1'b0;
         r_mat     <= 40'd0;
         r_virt    <= 5'd0;
         r_pressed <= 1'b0;
      end else begin
         r_pressed <= |w_eff;
         if (r_byte_vld) begin
            if (r_byte == 8'hE0) begin
               r_ext <= 1'b1;
            end else if (r_byte == 8'hF0) begin
               r_brk <= 1'b1;
            end else begin
               if (w_map_hit) begin
                  r_mat[w_map_idx] <= ~r_brk;
               end
               if (w_virt_hit) begin
                  r_virt[w_virt_idx] <= ~r_brk;
               end
               r_ext <= 1'b0;
               r_brk <= 1'b0;
            end
         end
      end
   end

   // Virtual keys each contribute CS plus one digit position
   always_comb begin
      w_virt_exp     = 40'd0;
      w_virt_exp[0]  = |r_virt;
      w_virt_exp[20] = r_virt[0];
      w_virt_exp[19] = r_virt[1];
      w_virt_exp[24] = r_virt[2];
      w_virt_exp[23] = r_virt[3];
      w_virt_exp[22] = r_virt[4];
   end

   assign w_eff = r_mat | w_virt_exp;

   // Wired-AND of all selected half-rows onto the active-low data bits
   always_comb begin
      key_row = 5'b11111;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 5; c++) begin
            if (!A_hi[r] && w_eff[r*5+c]) begin
               key_row[c] = 1'b0;
            end
         end
      end
   end

   assign pressed   = r_pressed;
   assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_keyboard_matrix.sv
// Directed bench for ps2_keyboard_matrix: PS/2 frames in, matrix reads checked via a scoreboard.
module tb_ps2_keyboard_matrix;

   logic       clk_cpu = 1'b0;
   logic       reset   = 1'b1;
   logic       PS2_CLK = 1'b1;
   logic       PS2_DAT = 1'b1;
   logic [7:0] A_hi    = 8'hFF;
   logic [4:0] key_row;
   logic       pressed;
   logic       frame_err;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] q_exp[$];
   string      q_tag[$];

   logic [7:0] err_cnt  = 8'd0;
   logic [7:0] run      = 8'd0;
   logic [7:0] last_run = 8'd0;
   logic [7:0] err_base;

   ps2_keyboard_matrix dut (
      .clk_cpu   (clk_cpu),
      .reset     (reset),
      .PS2_CLK   (PS2_CLK),
      .PS2_DAT   (PS2_DAT),
      .A_hi      (A_hi),
      .key_row   (key_row),
      .pressed   (pressed),
      .frame_err (frame_err)
   );

   always #5 clk_cpu = ~clk_cpu;

   // Count frame_err cycles and remember the width of the latest pulse
   always @(negedge clk_cpu) begin
      if (frame_err) begin
         err_cnt = err_cnt + 8'd1;
         run     = run + 8'd1;
      end else begin
         if (run != 8'd0) last_run = run;
         run = 8'd0;
      end
   end

   task automatic push(input string tag, input logic [7:0] v);
      q_exp.push_back(v);
      q_tag.push_back(tag);
   endtask

   task automatic cmp(input logic [7:0] obs);
      logic [7:0] e;
      string      t;
      e = q_exp.pop_front();
      t = q_tag.pop_front();
      n_cmp++;
      assert (obs === e) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", t, obs, e);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk_cpu);
   endtask

   task automatic chk_row(input string tag, input logic [7:0] a, input logic [4:0] exp);
      push(tag, {3'b000, exp});
      @(negedge clk_cpu);
      A_hi = a;
      #1;
      cmp({3'b000, key_row});
   endtask

   task automatic chk_pressed(input string tag, input logic exp);
      push(tag, {7'd0, exp});
      @(negedge clk_cpu);
      #1;
      cmp({7'd0, pressed});
   endtask

   task automatic chk_err(input string tag, input logic [7:0] exp_new);
      push(tag, exp_new);
      @(negedge clk_cpu);
      #1;
      cmp(err_cnt - err_base);
   endtask

   task automatic send_bit(input logic b);
      PS2_DAT = b;
      wait_clk(5);
      PS2_CLK = 1'b0;
      wait_clk(10);
      PS2_CLK = 1'b1;
      wait_clk(5);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic par_ok, input logic stop_ok);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(par_ok ? ~^b : ^b);
      send_bit(stop_ok);
      wait_clk(10);
   endtask

   task automatic key(input logic [7:0] b);
      send_byte(b, 1'b1, 1'b1);
   endtask

   initial begin
      err_base = 8'd0;
      wait_clk(4);
      @(negedge clk_cpu);
      reset = 1'b0;

      // Reset state
      chk_row("reset_row_00", 8'h00, 5'b11111);
      chk_pressed("reset_pressed", 1'b0);
      chk_err("reset_err", 8'd0);

      // 'A' make and break
      key(8'h1C);
      chk_row("a_make_fd", 8'hFD, 5'b11110);
      chk_row("a_make_fe", 8'hFE, 5'b11111);
      chk_pressed("a_make_pressed", 1'b1);
      key(8'hF0); key(8'h1C);
      chk_row("a_break_fd", 8'hFD, 5'b11111);
      chk_pressed("a_break_pressed", 1'b0);

      // LShift then cursor up: CS shared between direct and virtual sources
      key(8'h12);
      chk_row("lshift_fe", 8'hFE, 5'b11110);
      key(8'hE0); key(8'h75);
      chk_row("up_fe", 8'hFE, 5'b11110);
      chk_row("up_ef", 8'hEF, 5'b10111);
      key(8'hE0); key(8'hF0); key(8'h75);
      chk_row("up_rel_fe", 8'hFE, 5'b11110);
      chk_row("up_rel_ef", 8'hEF, 5'b11111);
      key(8'hF0); key(8'h12);
      chk_row("lshift_rel_fe", 8'hFE, 5'b11111);

      // Bad parity: one-cycle error, matrix untouched
      err_base = err_cnt;
      send_byte(8'h1C, 1'b0, 1'b1);
      chk_err("parity_err_cnt", 8'd1);
      push("parity_err_width", 8'd1);
      cmp(last_run);
      chk_row("parity_fd", 8'hFD, 5'b11111);
      chk_pressed("parity_pressed", 1'b0);

      // Bad stop bit and bad start bit
      err_base = err_cnt;
      send_byte(8'h1C, 1'b1, 1'b0);
      chk_err("stop_err_cnt", 8'd1);
      chk_row("stop_fd", 8'hFD, 5'b11111);
      err_base = err_cnt;
      send_bit(1'b1);
      wait_clk(5);
      chk_err("start_err_cnt", 8'd1);

      // Timeout after a partial frame
      err_base = err_cnt;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      wait_clk(11800);
      chk_err("tmo_early", 8'd0);
      wait_clk(300);
      chk_err("tmo_fired", 8'd1);
      key(8'h29);
      chk_row("space_7f", 8'h7F, 5'b11110);
      key(8'hF0); key(8'h29);
      chk_row("space_rel_7f", 8'h7F, 5'b11111);

      // Q and P held, then a one-cycle reset
      key(8'h15); key(8'h4D);
      chk_row("qp_fb", 8'hFB, 5'b11110);
      chk_row("qp_df", 8'hDF, 5'b11110);
      chk_row("qp_00", 8'h00, 5'b11110);
      @(negedge clk_cpu);
      reset = 1'b1;
      @(negedge clk_cpu);
      reset = 1'b0;
      #1;
      push("qp_reset_row", 8'h1F);
      cmp({3'b000, key_row});
      push("qp_reset_pressed", 8'h00);
      cmp({7'd0, pressed});

      // Reset mid-frame aborts silently; next frame decodes
      err_base = err_cnt;
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b0);
      @(negedge clk_cpu);
      reset = 1'b1;
      @(negedge clk_cpu);
      reset = 1'b0;
      wait_clk(20);
      chk_err("midreset_err", 8'd0);
      key(8'h1C);
      chk_row("midreset_a_fd", 8'hFD, 5'b11110);
      key(8'hF0); key(8'h1C);

      // Two-cycle clock glitch inside a frame must not shift in a bit
      err_base = err_cnt;
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      PS2_CLK = 1'b0;
      wait_clk(2);
      PS2_CLK = 1'b1;
      wait_clk(8);
      for (int i = 2; i < 8; i++) send_bit(i == 3 || i == 4);
      send_bit(~^8'h1A);
      send_bit(1'b1);
      wait_clk(10);
      chk_err("glitch_err", 8'd0);
      chk_row("glitch_z_fe", 8'hFE, 5'b11101);

      // Unmapped codes leave the matrix alone and clear prefixes
      key(8'hAA); key(8'hFA);
      chk_row("unmapped_fe", 8'hFE, 5'b11101);
      key(8'hE0); key(8'hAA); key(8'h14);
      chk_row("ext_cleared_ss", 8'h7F, 5'b11101);
      key(8'hF0); key(8'hFA); key(8'h1A);
      chk_row("brk_cleared_z", 8'hFE, 5'b11101);

      // Typematic repeat, then single release; release of an unheld key
      key(8'h1A);
      key(8'hF0); key(8'h1A);
      chk_row("typematic_rel_fe", 8'hFE, 5'b11111);
      key(8'hF0); key(8'h1D);
      chk_row("unheld_rel_fb", 8'hFB, 5'b11111);
      key(8'hE0); key(8'hF0); key(8'h14);
      chk_row("rctrl_rel_7f", 8'h7F, 5'b11111);
      chk_pressed("all_rel_pressed", 1'b0);

      // Backspace: CS + 0
      key(8'h66);
      chk_row("bksp_fe", 8'hFE, 5'b11110);
      chk_row("bksp_ef", 8'hEF, 5'b11110);
      key(8'hF0); key(8'h66);
      chk_row("bksp_rel_00", 8'h00, 5'b11111);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
